// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: record target codes, header size,
// last EEPROM address and the sequencer state type.
package boot_pkg;

  // Record target codes found in the first header byte.
  localparam logic [7:0] BOOT_TGT_CONTROL       = 8'h00;
  localparam logic [7:0] BOOT_TGT_MLU_SLICE     = 8'h01;
  localparam logic [7:0] BOOT_TGT_MLU_LOOKAHEAD = 8'h02;
  localparam logic [7:0] BOOT_TGT_END           = 8'hFF;

  // Header bytes per record: TARGET, LEN_LO, LEN_HI.
  localparam int BOOT_HDR_LEN = 3;

  // Highest EEPROM byte address; reading past it is an image error.
  localparam logic [16:0] BOOT_ROM_LAST = 17'h1_FFFF;

  typedef enum logic [3:0] {
    ST_HDR_T    = 4'd0,
    ST_HDR_L    = 4'd1,
    ST_HDR_H    = 4'd2,
    ST_DATA_RD  = 4'd3,
    ST_WE_SETUP = 4'd4,
    ST_WE_PULSE = 4'd5,
    ST_WE_HOLD  = 4'd6,
    ST_DONE     = 4'd7,
    ST_ERROR    = 4'd8
  } boot_state_e;

  // True for the three writable-store target codes (not END).
  function automatic logic boot_tgt_known(input logic [7:0] code);
    case (code)
      BOOT_TGT_CONTROL,
      BOOT_TGT_MLU_SLICE,
      BOOT_TGT_MLU_LOOKAHEAD: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/boot_rom_reader.sv
// EEPROM byte reader. While req is high it holds rom_addr with rom_n_oe low
// for ROM_WAIT+1 cycles, then pulses valid for one cycle with the byte on data
// and advances the address. The address never wraps: once the byte at
// ROM_LAST has been taken, overflow stays high.
// Ports: clk, rst_n (async, active low), req (read wanted), rom_data (EEPROM
// byte), rom_addr / rom_n_oe (EEPROM side), valid / data (sampled byte),
// overflow (last address consumed, including the consuming cycle).
module boot_rom_reader
  import boot_pkg::*;
#(
  parameter int          ROM_WAIT = 2,
  parameter logic [16:0] ROM_LAST = BOOT_ROM_LAST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [7:0]  rom_data,
  output logic [16:0] rom_addr,
  output logic        rom_n_oe,
  output logic        valid,
  output logic [7:0]  data,
  output logic        overflow
);

  localparam int            CW       = (ROM_WAIT > 1) ? $clog2(ROM_WAIT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ROM_WAIT);

  logic [CW-1:0] cnt_r;
  logic [16:0]   addr_r;
  logic          ovf_r;
  logic          valid_s;
  logic          at_last_s;

  assign valid_s   = req & (cnt_r == CNT_LAST);
  assign at_last_s = (addr_r == ROM_LAST);

  // Access-time counter: restarts for every byte and whenever no read is wanted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (valid_s || !req) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Address advance after each sampled byte; sticks at ROM_LAST instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= 17'd0;
      ovf_r  <= 1'b0;
    end else if (valid_s && at_last_s) begin
      ovf_r  <= 1'b1;
    end else if (valid_s) begin
      addr_r <= addr_r + 17'd1;
    end
  end

  // Output enable follows the request from the first cycle out of reset,
  // so the first byte gets its full access window.
  assign rom_n_oe = ~(req & rst_n);
  assign rom_addr = addr_r;
  assign valid    = valid_s;
  assign data     = rom_data;
  assign overflow = ovf_r | (valid_s & at_last_s);

endmodule

// File: rtl/boot_loader.sv
// Boot sequencer: walks the EEPROM image record by record and turns each data
// byte into a setup / N_WE pulse / hold write cycle on the selected store.
// Ports: CLK, N_RST (async, active low); ROM_DATA / ROM_ADDR / ROM_N_OE to the
// EEPROM; WR_ADDR / WR_DATA plus CONTROL_N_WE, MLU_SLICE_N_WE,
// MLU_LOOKAHEAD_N_WE to the stores; N_BOOTED (low after a clean END record)
// and BOOT_ERR (sticky image error).
module boot_loader
  import boot_pkg::*;
#(
  parameter int          ROM_WAIT  = 2,
  parameter int          WE_CYCLES = 1,
  parameter logic [16:0] ROM_LAST  = BOOT_ROM_LAST
) (
  input  logic        CLK,
  input  logic        N_RST,
  input  logic [7:0]  ROM_DATA,
  output logic [16:0] ROM_ADDR,
  output logic        ROM_N_OE,
  output logic [15:0] WR_ADDR,
  output logic [7:0]  WR_DATA,
  output logic        CONTROL_N_WE,
  output logic        MLU_SLICE_N_WE,
  output logic        MLU_LOOKAHEAD_N_WE,
  output logic        N_BOOTED,
  output logic        BOOT_ERR
);

  localparam int             WCW     = $clog2(WE_CYCLES + 1);
  localparam logic [WCW-1:0] WE_LAST = WCW'(WE_CYCLES - 1);

  boot_state_e    state_r, state_s;
  logic [1:0]     tgt_r, tgt_nx;
  logic [15:0]    len_r, len_nx;
  logic [15:0]    wr_addr_r, wr_addr_nx;
  logic [7:0]     wr_data_r, wr_data_nx;
  logic [WCW-1:0] we_cnt_r, we_cnt_nx;
  logic [2:0]     n_we_r, n_we_nx;      // {lookahead, slice, control}
  logic           n_booted_r, n_booted_nx;
  logic           boot_err_r, boot_err_nx;

  logic           rd_req_s, rd_valid_s, rd_ovf_s;
  logic [7:0]     rd_data_s;
  logic           last_byte_s;

  assign rd_req_s    = (state_r == ST_HDR_T) || (state_r == ST_HDR_L) ||
                       (state_r == ST_HDR_H) || (state_r == ST_DATA_RD);
  assign last_byte_s = (wr_addr_r == (len_r - 16'd1));

  boot_rom_reader #(.ROM_WAIT(ROM_WAIT), .ROM_LAST(ROM_LAST)) u_reader (
    .clk      (CLK),
    .rst_n    (N_RST),
    .req      (rd_req_s),
    .rom_data (ROM_DATA),
    .rom_addr (ROM_ADDR),
    .rom_n_oe (ROM_N_OE),
    .valid    (rd_valid_s),
    .data     (rd_data_s),
    .overflow (rd_ovf_s)
  );

  // State register.
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state_r <= ST_HDR_T;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state. Any move into a reading state after the EEPROM is exhausted is an error.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_HDR_T: begin
        if (!rd_valid_s)                                    state_s = state_r;
        else if (rd_data_s == BOOT_TGT_END)                 state_s = ST_DONE;
        else if (!boot_tgt_known(rd_data_s) || rd_ovf_s)    state_s = ST_ERROR;
        else                                                state_s = ST_HDR_L;
      end
      ST_HDR_L: begin
        if (!rd_valid_s)   state_s = state_r;
        else if (rd_ovf_s) state_s = ST_ERROR;
        else               state_s = ST_HDR_H;
      end
      ST_HDR_H: begin
        if (!rd_valid_s)                            state_s = state_r;
        else if (rd_ovf_s)                          state_s = ST_ERROR;
        else if ({rd_data_s, len_r[7:0]} == 16'd0)  state_s = ST_HDR_T;
        else                                        state_s = ST_DATA_RD;
      end
      ST_DATA_RD: begin
        if (rd_valid_s) state_s = ST_WE_SETUP;
        else            state_s = state_r;
      end
      ST_WE_SETUP: state_s = ST_WE_PULSE;
      ST_WE_PULSE: begin
        if (we_cnt_r == WE_LAST) state_s = ST_WE_HOLD;
        else                     state_s = state_r;
      end
      ST_WE_HOLD: begin
        if (rd_ovf_s)         state_s = ST_ERROR;
        else if (last_byte_s) state_s = ST_HDR_T;
        else                  state_s = ST_DATA_RD;
      end
      ST_DONE:  state_s = ST_DONE;
      ST_ERROR: state_s = ST_ERROR;
      default:  state_s = ST_ERROR;
    endcase
  end

  // Next values of datapath and output flops. N_WE is decoded from the next
  // state so the pulse lines up exactly with WE_PULSE.
  always_comb begin
    tgt_nx     = tgt_r;
    len_nx     = len_r;
    wr_addr_nx = wr_addr_r;
    wr_data_nx = wr_data_r;
    we_cnt_nx  = '0;
    n_we_nx    = 3'b111;
    if (rd_valid_s) begin
      case (state_r)
        ST_HDR_T:   tgt_nx = rd_data_s[1:0];
        ST_HDR_L:   len_nx = {len_r[15:8], rd_data_s};
        ST_HDR_H: begin
          len_nx     = {rd_data_s, len_r[7:0]};
          wr_addr_nx = 16'd0;
        end
        ST_DATA_RD: wr_data_nx = rd_data_s;
        default:    tgt_nx = tgt_r;
      endcase
    end else begin
      tgt_nx = tgt_r;
    end
    if ((state_r == ST_WE_HOLD) && (state_s == ST_DATA_RD)) begin
      wr_addr_nx = wr_addr_r + 16'd1;
    end else begin
      wr_addr_nx = wr_addr_nx;
    end
    if ((state_r == ST_WE_PULSE) && (state_s == ST_WE_PULSE)) begin
      we_cnt_nx = we_cnt_r + WCW'(1);
    end else begin
      we_cnt_nx = '0;
    end
    if (state_s == ST_WE_PULSE) begin
      case (tgt_r)
        2'd0:    n_we_nx = 3'b110;
        2'd1:    n_we_nx = 3'b101;
        2'd2:    n_we_nx = 3'b011;
        default: n_we_nx = 3'b111;
      endcase
    end else begin
      n_we_nx = 3'b111;
    end
    n_booted_nx = (state_s != ST_DONE);
    boot_err_nx = (state_s == ST_ERROR);
  end

  // Datapath and output flops; reset forces every write enable high at once.
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      tgt_r      <= 2'd0;
      len_r      <= 16'd0;
      wr_addr_r  <= 16'd0;
      wr_data_r  <= 8'd0;
      we_cnt_r   <= '0;
      n_we_r     <= 3'b111;
      n_booted_r <= 1'b1;
      boot_err_r <= 1'b0;
    end else begin
      tgt_r      <= tgt_nx;
      len_r      <= len_nx;
      wr_addr_r  <= wr_addr_nx;
      wr_data_r  <= wr_data_nx;
      we_cnt_r   <= we_cnt_nx;
      n_we_r     <= n_we_nx;
      n_booted_r <= n_booted_nx;
      boot_err_r <= boot_err_nx;
    end
  end

  assign WR_ADDR            = wr_addr_r;
  assign WR_DATA            = wr_data_r;
  assign CONTROL_N_WE       = n_we_r[0];
  assign MLU_SLICE_N_WE     = n_we_r[1];
  assign MLU_LOOKAHEAD_N_WE = n_we_r[2];
  assign N_BOOTED           = n_booted_r;
  assign BOOT_ERR           = boot_err_r;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: two instances share clock and reset. "dut" sees the
// full 17-bit EEPROM; "dut_small" is built with a 256-byte EEPROM so the
// end-of-ROM error is reachable in a short run. A record-level model predicts
// the write list, the end kind, the end cycle and the final ROM address.
module tb_boot_loader;
  import boot_pkg::*;

  localparam int ROM_WAIT  = 2;
  localparam int WE_CYCLES = 1;
  localparam int RD_CYC    = ROM_WAIT + 1;
  localparam int WR_CYC    = 2 + WE_CYCLES;
  localparam int LAST1     = 255;
  localparam int BUDGET    = 6000;

  logic CLK = 1'b0;
  logic N_RST = 1'b0;

  logic [7:0]  rom0 [0:4095];
  logic [7:0]  rom1 [0:255];
  logic [7:0]  rom_data [2];
  logic [16:0] rom_addr [2];
  logic        rom_n_oe [2];
  logic [15:0] wr_addr  [2];
  logic [7:0]  wr_data  [2];
  logic        ctl_n_we [2];
  logic        sl_n_we  [2];
  logic        la_n_we  [2];
  logic        n_booted [2];
  logic        boot_err [2];

  int checks = 0;
  int errors = 0;
  logic [25:0] exp_w0[$], exp_w1[$], act_w0[$], act_w1[$], keep_w0[$];
  int exp_kind[2], exp_t[2], exp_pos[2], act_kind[2], act_t[2];

  always #5 CLK = ~CLK;

  assign rom_data[0] = (rom_addr[0] < 17'd4096) ? rom0[rom_addr[0][11:0]] : 8'hEE;
  assign rom_data[1] = (rom_addr[1] <= 17'd255) ? rom1[rom_addr[1][7:0]] : 8'hEE;

  boot_loader #(.ROM_WAIT(ROM_WAIT), .WE_CYCLES(WE_CYCLES)) dut (
    .CLK(CLK), .N_RST(N_RST), .ROM_DATA(rom_data[0]), .ROM_ADDR(rom_addr[0]),
    .ROM_N_OE(rom_n_oe[0]), .WR_ADDR(wr_addr[0]), .WR_DATA(wr_data[0]),
    .CONTROL_N_WE(ctl_n_we[0]), .MLU_SLICE_N_WE(sl_n_we[0]),
    .MLU_LOOKAHEAD_N_WE(la_n_we[0]), .N_BOOTED(n_booted[0]), .BOOT_ERR(boot_err[0]));

  boot_loader #(.ROM_WAIT(ROM_WAIT), .WE_CYCLES(WE_CYCLES), .ROM_LAST(17'd255)) dut_small (
    .CLK(CLK), .N_RST(N_RST), .ROM_DATA(rom_data[1]), .ROM_ADDR(rom_addr[1]),
    .ROM_N_OE(rom_n_oe[1]), .WR_ADDR(wr_addr[1]), .WR_DATA(wr_data[1]),
    .CONTROL_N_WE(ctl_n_we[1]), .MLU_SLICE_N_WE(sl_n_we[1]),
    .MLU_LOOKAHEAD_N_WE(la_n_we[1]), .N_BOOTED(n_booted[1]), .BOOT_ERR(boot_err[1]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] wev(input int k);
    return {la_n_we[k], sl_n_we[k], ctl_n_we[k]};
  endfunction

  function automatic int rb(input int k, input int a);
    if (k == 1) return (a <= LAST1) ? int'(rom1[a]) : 238;
    else        return (a < 4096) ? int'(rom0[a]) : 238;
  endfunction

  // One byte as the sequencer sees it: costs a full read window, and the
  // address stops at the last byte instead of moving on.
  task automatic rd(input int k, input int last, inout int pos, inout int t,
                    inout bit exh, output int v);
    t += RD_CYC;
    v = rb(k, pos);
    if (pos == last) exh = 1'b1;
    else             pos++;
  endtask

  // Record-level model: kind 1 = clean END, 2 = image error.
  task automatic model(input int k);
    int pos, t, tg, lo, hi, d, len, kind, last;
    bit exh;
    logic [25:0] q[$];
    logic [1:0] t2;
    logic [15:0] a16;
    logic [7:0] d8;
    last = (k == 1) ? LAST1 : 131071;
    pos = 0; t = 0; exh = 1'b0; kind = 0; q = {};
    while (kind == 0) begin
      rd(k, last, pos, t, exh, tg);
      if (tg == 255)            kind = 1;
      else if (tg > 2 || exh)   kind = 2;
      else begin
        hi = 0; lo = 0;
        rd(k, last, pos, t, exh, lo);
        if (exh) kind = 2;
        else begin
          rd(k, last, pos, t, exh, hi);
          if (exh) kind = 2;
        end
        len = (kind == 0) ? hi * 256 + lo : 0;
        for (int i = 0; i < len && kind == 0; i++) begin
          rd(k, last, pos, t, exh, d);
          t += WR_CYC;
          t2 = tg[1:0]; a16 = i[15:0]; d8 = d[7:0];
          q.push_back({t2, a16, d8});
          if (exh) kind = 2;
        end
      end
    end
    exp_kind[k] = kind; exp_t[k] = t; exp_pos[k] = pos;
    if (k == 1) exp_w1 = q;
    else        exp_w0 = q;
  endtask

  // Reset, release, watch both instances cycle by cycle, then compare to the model.
  task automatic run(input bit abort_en, output bit aborted);
    int cyc;
    bit fin [2];
    int lowlen [2];
    logic [2:0] prev [2];
    logic [2:0] we;
    logic [15:0] la [2];
    logic [7:0] ld [2];
    logic [1:0] tg;
    aborted = 1'b0;
    act_w0 = {}; act_w1 = {};
    N_RST = 1'b0;
    repeat (2) @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      chk("rst_rom_addr", rom_addr[k], 0);
      chk("rst_rom_n_oe", rom_n_oe[k], 1);
      chk("rst_wr_addr", wr_addr[k], 0);
      chk("rst_wr_data", wr_data[k], 0);
      chk("rst_n_we", wev(k), 7);
      chk("rst_n_booted", n_booted[k], 1);
      chk("rst_boot_err", boot_err[k], 0);
      fin[k] = 1'b0; lowlen[k] = 0; prev[k] = 3'b111; act_kind[k] = 0; act_t[k] = 0;
    end
    N_RST = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) chk("first_read_oe", rom_n_oe[k], 0);
    cyc = 0;
    while (!(fin[0] && fin[1]) && cyc < BUDGET) begin
      @(posedge CLK);
      cyc++;
      #1;
      for (int k = 0; k < 2; k++) begin
        we = wev(k);
        chk("one_n_we_low", ($countones(~we) <= 1), 1);
        chk("booted_without_err", (!n_booted[k] && boot_err[k]), 0);
        if (we != 3'b111) begin
          if (prev[k] == 3'b111) begin
            tg = !we[0] ? 2'd0 : (!we[1] ? 2'd1 : 2'd2);
            if (k == 0) act_w0.push_back({tg, wr_addr[k], wr_data[k]});
            else        act_w1.push_back({tg, wr_addr[k], wr_data[k]});
            la[k] = wr_addr[k]; ld[k] = wr_data[k]; lowlen[k] = 1;
          end else begin
            lowlen[k]++;
            chk("wr_stable", {wr_addr[k], wr_data[k]}, {la[k], ld[k]});
          end
        end else if (prev[k] != 3'b111) begin
          chk("we_width", lowlen[k], WE_CYCLES);
        end
        prev[k] = we;
        if (!fin[k] && (!n_booted[k] || boot_err[k])) begin
          fin[k] = 1'b1; act_t[k] = cyc; act_kind[k] = !n_booted[k] ? 1 : 2;
        end
      end
      if (abort_en && act_w0.size() == 2 && wev(0) != 3'b111) begin
        #3 N_RST = 1'b0;
        #1;
        chk("abort_n_we_high0", wev(0), 7);
        chk("abort_n_we_high1", wev(1), 7);
        for (int i = 0; i < 2; i++) chk("abort_prefix", act_w0[i], exp_w0[i]);
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      for (int k = 0; k < 2; k++) begin
        chk("finished_in_budget", fin[k], 1);
        chk("end_kind", act_kind[k], exp_kind[k]);
        chk("end_cycle", act_t[k], exp_t[k]);
        chk("end_rom_addr", rom_addr[k], exp_pos[k]);
        chk("end_rom_n_oe", rom_n_oe[k], 1);
        chk("end_n_we", wev(k), 7);
        chk("end_n_booted", n_booted[k], (exp_kind[k] == 1) ? 0 : 1);
        chk("end_boot_err", boot_err[k], (exp_kind[k] == 2) ? 1 : 0);
      end
      chk("write_count0", act_w0.size(), exp_w0.size());
      for (int i = 0; i < act_w0.size() && i < exp_w0.size(); i++) chk("write0", act_w0[i], exp_w0[i]);
      chk("write_count1", act_w1.size(), exp_w1.size());
      for (int i = 0; i < act_w1.size() && i < exp_w1.size(); i++) chk("write1", act_w1[i], exp_w1[i]);
    end
  endtask

  task automatic load0(input logic [7:0] img[$]);
    foreach (rom0[i]) rom0[i] = 8'hFF;
    foreach (img[i]) rom0[i] = img[i];
  endtask

  task automatic rand0(input bit allow_bad, input bit long_rec);
    int p, nrec, tg, len;
    foreach (rom0[i]) rom0[i] = 8'hFF;
    p = 0;
    nrec = $urandom_range(1, 4);
    for (int r = 0; r < nrec; r++) begin
      tg = $urandom_range(0, 2);
      if (allow_bad && r == nrec - 1) tg = $urandom_range(3, 254);
      len = (r == 0) ? $urandom_range(1, 6) : $urandom_range(0, 6);
      if (long_rec && r == 0) len = 258;
      rom0[p] = tg[7:0]; rom0[p+1] = len[7:0]; rom0[p+2] = len[15:8];
      p += 3;
      for (int i = 0; i < len; i++) begin
        rom0[p] = 8'($urandom);
        p++;
      end
    end
    rom0[p] = 8'hFF;
  endtask

  task automatic put1(input int a, input int v);
    if (a <= LAST1) rom1[a] = v[7:0];
  endtask

  // Small-ROM image with no END record: always runs off the last address.
  task automatic rand1();
    int p, len;
    foreach (rom1[i]) rom1[i] = 8'h00;
    p = 0;
    while (p <= LAST1) begin
      len = $urandom_range(0, 4);
      put1(p, $urandom_range(0, 2)); put1(p + 1, len); put1(p + 2, 0);
      p += 3;
      for (int i = 0; i < len; i++) begin
        put1(p, $urandom_range(0, 255));
        p++;
      end
    end
  endtask

  initial begin
    logic [7:0] img[$];
    bit ab;

    // Two control writes then END; small ROM all zero (empty records to the end).
    img = {8'h00, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'hFF};
    load0(img);
    foreach (rom1[i]) rom1[i] = 8'h00;
    model(0); model(1);
    run(1'b0, ab);
    chk("tp1_booted_cycle", act_t[0], 24);
    chk("tp1_write_a", act_w0.size() > 0 ? act_w0[0] : 26'h3FFFFFF, {2'd0, 16'h0000, 8'hAA});
    chk("tp1_write_b", act_w0.size() > 1 ? act_w0[1] : 26'h3FFFFFF, {2'd0, 16'h0001, 8'hBB});
    chk("small_rom_err_cycle", act_t[1], 768);
    chk("small_rom_no_wrap", rom_addr[1], 255);

    // Empty slice record skipped, one lookahead write.
    img = {8'h01, 8'h00, 8'h00, 8'h02, 8'h01, 8'h00, 8'h5C, 8'hFF};
    load0(img);
    rand1();
    model(0); model(1);
    run(1'b0, ab);
    chk("tp2_writes", act_w0.size(), 1);
    chk("tp2_write", act_w0.size() > 0 ? act_w0[0] : 26'h3FFFFFF, {2'd2, 16'h0000, 8'h5C});
    chk("tp2_done", act_kind[0], 1);

    // Unknown target code on the first header byte.
    img = {8'h07, 8'h01, 8'h00, 8'h12, 8'hFF};
    load0(img);
    rand1();
    model(0); model(1);
    run(1'b0, ab);
    chk("tp3_err_cycle", act_t[0], 3);
    chk("tp3_no_writes", act_w0.size(), 0);
    chk("tp3_n_booted", n_booted[0], 1);

    // Long record crossing LEN_HI and a WR_ADDR low-byte carry.
    rand0(1'b0, 1'b1);
    rand1();
    model(0); model(1);
    run(1'b0, ab);

    // Random images, some ending on a bad target code.
    for (int n = 0; n < 6; n++) begin
      rand0(n[0], 1'b0);
      rand1();
      model(0); model(1);
      run(1'b0, ab);
    end

    // Reset during the second write pulse; the reload must match the full run.
    img = {8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h02, 8'h02, 8'h00, 8'h44, 8'h55, 8'hFF};
    load0(img);
    rand1();
    model(0); model(1);
    run(1'b0, ab);
    keep_w0 = act_w0;
    run(1'b1, ab);
    chk("abort_reached", ab, 1);
    run(1'b0, ab);
    chk("reload_count", act_w0.size(), keep_w0.size());
    for (int i = 0; i < act_w0.size() && i < keep_w0.size(); i++) chk("reload_write", act_w0[i], keep_w0[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
